// File: rtl/pc_target_predictor_pkg.sv
// Shared constants and helpers for the PC target predictor and its BTB.
package pc_target_predictor_pkg;

    localparam int unsigned PC_INC = 4;

    // Counter encodings are MSB-as-direction; derived per counter width.
    function automatic int unsigned weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/pc_target_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load and asynchronous reset value.
module btb_sat_counter #(
    parameter int unsigned    W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_inc && !i_dec && cnt_q != '1) begin
            cnt_d = cnt_q + W'(1);
        end else if (i_dec && !i_inc && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= RST_VAL;
        else       cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;
endmodule

// File: rtl/pc_target_predictor.sv
// Execute-stage target computation plus a direct-mapped BTB with direction
// counters that feeds fetch predictions and flags execute-stage mispredicts.
module pc_target_predictor
    import pc_target_predictor_pkg::*;
#(
    parameter int unsigned PC_Width     = 32,
    parameter int unsigned immext_width = 32,
    parameter int unsigned BTB_Entries  = 16,
    parameter int unsigned Cnt_Width    = 2,
    parameter int unsigned Stat_Width   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [PC_Width-1:0]     i_PC_F,
    output logic                    o_pred_taken_F,
    output logic [PC_Width-1:0]     o_pred_target_F,
    input  logic                    i_valid_E,
    input  logic [PC_Width-1:0]     i_PC_E,
    input  logic [immext_width-1:0] i_immExt_E,
    input  logic [immext_width-1:0] i_RS1_E,
    input  logic                    i_Jal_R_E,
    input  logic                    i_Jump_E,
    input  logic                    i_Branch_E,
    input  logic                    i_Branch_taken_E,
    input  logic                    i_pred_taken_E,
    input  logic [PC_Width-1:0]     i_pred_target_E,
    output logic [PC_Width-1:0]     o_PC_target_E,
    output logic                    o_mispredict_E,
    output logic [PC_Width-1:0]     o_PC_redirect_E,
    output logic [Stat_Width-1:0]   o_ctrl_count,
    output logic [Stat_Width-1:0]   o_mispredict_count
);
    localparam int unsigned IDXW = idx_w(BTB_Entries);
    localparam int unsigned TAGW = PC_Width - IDXW - 2;
    localparam logic [Cnt_Width-1:0] WEAK_TAKEN     = Cnt_Width'(weak_taken(Cnt_Width));
    localparam logic [Cnt_Width-1:0] WEAK_NOT_TAKEN = Cnt_Width'(weak_not_taken(Cnt_Width));

    logic [BTB_Entries-1:0]                valid_q, valid_d;
    logic [BTB_Entries-1:0]                jump_q, jump_d;
    logic [BTB_Entries-1:0][TAGW-1:0]      tag_q, tag_d;
    logic [BTB_Entries-1:0][PC_Width-1:0]  target_q, target_d;
    logic [BTB_Entries-1:0][Cnt_Width-1:0] cnt;
    logic [BTB_Entries-1:0]                cnt_inc, cnt_dec, cnt_load;

    logic [IDXW-1:0]     idx_f, idx_e;
    logic [TAGW-1:0]     tag_f, tag_e;
    logic                hit_f, hit_e;
    logic [PC_Width-1:0] base_e, pc_target, pc_plus4;
    logic                act_taken, ctrl;
    logic                unused_pc_f_lo;

    assign unused_pc_f_lo = ^i_PC_F[1:0];

    // Target computation
    assign base_e        = i_Jal_R_E ? i_RS1_E : i_PC_E;
    assign pc_target     = (base_e + i_immExt_E) & ~PC_Width'(i_Jal_R_E);
    assign pc_plus4      = i_PC_E + PC_Width'(PC_INC);
    assign o_PC_target_E = pc_target;

    // Fetch lookup reads pre-edge contents; no bypass from the execute update.
    assign idx_f           = i_PC_F[IDXW+1:2];
    assign tag_f           = i_PC_F[PC_Width-1:IDXW+2];
    assign hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign o_pred_taken_F  = hit_f && (jump_q[idx_f] || cnt[idx_f][Cnt_Width-1]);
    assign o_pred_target_F = o_pred_taken_F ? target_q[idx_f] : '0;

    // Resolution
    assign idx_e     = i_PC_E[IDXW+1:2];
    assign tag_e     = i_PC_E[PC_Width-1:IDXW+2];
    assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign ctrl      = i_valid_E && (i_Jump_E || i_Branch_E);
    assign act_taken = i_Jump_E || (i_Branch_E && i_Branch_taken_E);

    assign o_mispredict_E  = i_valid_E && ((i_pred_taken_E != act_taken) ||
                             (act_taken && (i_pred_target_E != pc_target)));
    assign o_PC_redirect_E = act_taken ? pc_target : pc_plus4;

    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_inc  = '0;
        cnt_dec  = '0;
        cnt_load = '0;
        if (ctrl) begin
            if (hit_e) begin
                cnt_inc[idx_e] = act_taken;
                cnt_dec[idx_e] = !act_taken;
                if (act_taken) begin
                    target_d[idx_e] = pc_target;
                    jump_d[idx_e]   = i_Jump_E;
                end
            end else if (act_taken) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = pc_target;
                jump_d[idx_e]   = i_Jump_E;
                cnt_load[idx_e] = 1'b1;
            end
        end else if (i_valid_E && hit_e) begin
            // A non-control instruction hit the table: drop the stale alias.
            valid_d[idx_e] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q  <= '0;
            jump_q   <= '0;
            tag_q    <= '0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            jump_q   <= jump_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    for (genvar g = 0; g < int'(BTB_Entries); g++) begin : g_dir_cnt
        btb_sat_counter #(.W(Cnt_Width), .RST_VAL(WEAK_NOT_TAKEN)) u_cnt (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_inc      (cnt_inc[g]),
            .i_dec      (cnt_dec[g]),
            .i_load     (cnt_load[g]),
            .i_load_val (WEAK_TAKEN),
            .o_cnt      (cnt[g])
        );
    end

    btb_sat_counter #(.W(Stat_Width), .RST_VAL('0)) u_ctrl_stat (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (ctrl),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (o_ctrl_count)
    );

    btb_sat_counter #(.W(Stat_Width), .RST_VAL('0)) u_misp_stat (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (o_mispredict_E),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (o_mispredict_count)
    );
endmodule

// File: doc/pc_target_predictor.md
Name: pc_target_predictor

Overview:
- Next-generation PC target unit. It computes the execute-stage jump/branch target (PC+imm or RS1+imm) exactly as before.
- It adds a parametrised direct-mapped branch target buffer (BTB) with saturating direction counters. The fetch stage reads the BTB to get a predicted next PC.
- The execute stage resolves each control-flow instruction, updates the table and flags mispredictions for the hazard/redirect logic.
- It sits between the fetch PC mux and the execute stage.

Parameters:
- PC_Width, 32, width of PC, targets and RS1.
- immext_width, 32, width of sign-extended immediate; must equal PC_Width.
- BTB_Entries, 16, number of BTB entries; power of two, at least 2.
- Cnt_Width, 2, width of each saturating direction counter.
- Stat_Width, 16, width of the statistics counters.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_PC_F  input  PC_Width  fetch-stage PC used for lookup.
- o_pred_taken_F  output  1  prediction: next PC is o_pred_target_F.
- o_pred_target_F  output  PC_Width  predicted target; 0 when not taken.
- i_valid_E  input  1  execute-stage instruction is valid (not bubble/flushed).
- i_PC_E  input  PC_Width  execute-stage PC.
- i_immExt_E  input  immext_width  extended immediate.
- i_RS1_E  input  immext_width  forwarded RS1 value.
- i_Jal_R_E  input  1  instruction is JALR.
- i_Jump_E  input  1  instruction is JAL or JALR.
- i_Branch_E  input  1  instruction is a conditional branch.
- i_Branch_taken_E  input  1  branch condition result from the ALU.
- i_pred_taken_E  input  1  o_pred_taken_F, pipelined to execute by the datapath.
- i_pred_target_E  input  PC_Width  o_pred_target_F, pipelined to execute.
- o_PC_target_E  output  PC_Width  computed target.
- o_mispredict_E  output  1  flush and redirect request.
- o_PC_redirect_E  output  PC_Width  correct next PC, valid when o_mispredict_E is 1.
- o_ctrl_count  output  Stat_Width  resolved control-flow instructions.
- o_mispredict_count  output  Stat_Width  mispredictions.

Behaviour:
- Target computation:
  - base = i_Jal_R_E ? i_RS1_E : i_PC_E.
  - sum = base + i_immExt_E, modulo 2^PC_Width.
  - For JALR, bit 0 of the target is forced to 0.
  - Combinational, zero latency.
- Indexing:
  - idx = PC[IDXW+1:2], where IDXW = log2(BTB_Entries).
  - tag = PC[PC_Width-1:IDXW+2].
  - Each entry holds: valid, tag, target, cnt[Cnt_Width], is_jump.
- Lookup (combinational from i_PC_F):
  - hit = valid & tag match.
  - o_pred_taken_F = hit & (is_jump | cnt MSB).
  - o_pred_target_F = entry target when predicted taken, else 0.
- Resolution (combinational), with ctrl = i_valid_E & (i_Jump_E | i_Branch_E):
  - act_taken = i_Jump_E | (i_Branch_E & i_Branch_taken_E).
  - act_next = act_taken ? target : i_PC_E + 4.
  - o_mispredict_E = i_valid_E & ((i_pred_taken_E != act_taken) | (act_taken & i_pred_target_E != target)).
  - o_PC_redirect_E = act_next.
  - A non-control instruction predicted taken (alias) mispredicts and redirects to PC+4.
- Update (rising edge, entry idx(i_PC_E)):
  - Hit and ctrl: counter increments on taken, decrements on not-taken, saturating at all-ones / 0. Target and is_jump are rewritten when taken.
  - Miss and ctrl and taken: allocate (overwrite) the entry. Set valid=1, tag, target, is_jump. Counter is set to weakly-taken (MSB=1, rest 0).
  - Miss and ctrl and not-taken: no change.
  - i_valid_E and not ctrl and hit: clear valid (alias removal).
  - i_valid_E=0: no state change, no counter change, o_mispredict_E=0.
- Simultaneous lookup and update of the same index: fetch sees the pre-edge contents (no bypass). The update is visible the next cycle.
- Statistics:
  - o_ctrl_count increments on each ctrl cycle.
  - o_mispredict_count increments on each o_mispredict_E cycle.
  - Both saturate at all-ones; no wrap.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits = 0.
  - All counters = weakly-not-taken (MSB=0, rest 1).
  - Targets and tags = 0.
  - Statistics = 0.
  - During and after reset: o_pred_taken_F=0, o_pred_target_F=0. Execute outputs follow the combinational rules.

Decomposition:
- Shared package holds:
  - constants WEAK_TAKEN and WEAK_NOT_TAKEN (derived from Cnt_Width);
  - PC increment constant 4;
  - IDXW derivation function (clog2).
- One natural sub-module: btb_sat_counter (parametrised saturating up/down counter with reset value). It is reused for the Stat_Width counters with decrement tied off.

Test Plan:
- Reset, then i_PC_F=0x100 -> o_pred_taken_F=0, o_pred_target_F=0; both statistics = 0.
- JAL at PC=0x100, imm=0x40, pred_taken=0 -> o_PC_target_E=0x140, mispredict=1, redirect=0x140. Next cycle: i_PC_F=0x100 gives pred_taken=1, target=0x140.
- JALR with RS1=0x2001, imm=0x10 -> target=0x2010 (bit 0 cleared). With pred_target=0x2010 and pred_taken=1 -> mispredict=0.
- Branch at PC=0x200, imm=-8:
  - Taken twice -> counter saturates at 11.
  - Three not-taken -> counter 00; lookup at 0x200 predicts not-taken.
  - Not-taken with pred_taken=1 -> mispredict, redirect=0x204.
- Aliasing: entry allocated at 0x100; a non-branch at 0x100+4*BTB_Entries has a tag mismatch, so lookup pred=0. A non-branch at 0x100 with i_pred_taken_E=1 -> mispredict, redirect 0x104, valid cleared.
- Assert i_rst during an update cycle -> table and counters cleared immediately. o_mispredict_count=0 and o_pred_taken_F=0 after release.
